address_calc_ring: RTL and testbench

Parametrised address generator for the convolution datapath. It drives one SDRAM address (frame read / result write) and one SRAM address (row-cache ring / output line buffer) from per-transfer update strobes. Relative to the single-line generator it adds:
- a ROWS-deep row-cache ring;
- a kernel-trimmed output line;
- frame-size bookkeeping with done flags;
- configuration latched at start.

It sits between the transfer controller and the SRAM/SDRAM interface blocks.

---
 rtl/address_calc_ring.sv | 198 +++++++++++++++++++
 tb/tb_address_calc_ring.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/address_calc_ring.sv
// Address generator for the convolution datapath: SDRAM frame read/result write
// pointers plus an SRAM row-cache ring and a kernel-trimmed output line pointer.
module address_calc_ring #(
  parameter int ADDR_W = 26,
  parameter int DIM_W  = 13,
  parameter int ROWS   = 3,
  parameter int KERNEL = 3,
  localparam int LINE_W = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start_flag,
  input  logic [DIM_W-1:0]  image_width,
  input  logic [DIM_W-1:0]  image_height,
  input  logic [ADDR_W-1:0] start_address_sdram,
  input  logic [ADDR_W-1:0] finish_address_sdram,
  input  logic [ADDR_W-1:0] rowCache_address_sram,
  input  logic [ADDR_W-1:0] output_address_sram,
  input  logic              sram_mode,
  input  logic              sdram_mode,
  input  logic              sram_update,
  input  logic              sdram_update,
  output logic [ADDR_W-1:0] sram_address,
  output logic [ADDR_W-1:0] sdram_address,
  output logic [LINE_W-1:0] row_line,
  output logic              row_wrap,
  output logic              read_done,
  output logic              write_done
);

  localparam int TOT_W = 2 * DIM_W;

  localparam logic [DIM_W-1:0]  KERN_D    = DIM_W'(KERNEL);
  localparam logic [DIM_W-1:0]  ONE_D     = DIM_W'(1);
  localparam logic [DIM_W-1:0]  ZERO_D    = DIM_W'(0);
  localparam logic [TOT_W-1:0]  ONE_T     = TOT_W'(1);
  localparam logic [TOT_W-1:0]  ZERO_T    = TOT_W'(0);
  localparam logic [ADDR_W-1:0] ONE_A     = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ZERO_A    = ADDR_W'(0);
  localparam logic [LINE_W-1:0] LINE_ONE  = LINE_W'(1);
  localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(ROWS - 1);
  localparam logic [LINE_W-1:0] LINE_ZERO = LINE_W'(0);

  logic [DIM_W-1:0]  width_r;
  logic [ADDR_W-1:0] start_base_r, finish_base_r, rc_base_r, out_base_r;
  logic [TOT_W-1:0]  rd_total_r, wr_total_r;
  logic [ADDR_W-1:0] rd_off_r, wr_off_r;
  logic [TOT_W-1:0]  rd_cnt_r, wr_cnt_r;
  logic              read_done_r, write_done_r;
  logic [DIM_W-1:0]  col_r;
  logic [LINE_W-1:0] line_r;
  logic [ADDR_W-1:0] line_base_r;
  logic              row_wrap_r;
  logic [DIM_W-1:0]  out_col_r;

  logic [TOT_W-1:0]  rd_total_s, wr_total_s;
  logic              col_last_s, line_last_s, out_short_s, out_last_s;

  // Frame totals from the live inputs, latched only on start_flag
  always_comb begin
    rd_total_s = TOT_W'(image_width) * TOT_W'(image_height);
    if ((image_width < KERN_D) || (image_height < KERN_D)) begin
      wr_total_s = ZERO_T;
    end else begin
      wr_total_s = TOT_W'(image_width - KERN_D + ONE_D) * TOT_W'(image_height - KERN_D + ONE_D);
    end
  end

  // Pointer wrap conditions derived from the latched width
  always_comb begin
    col_last_s  = (col_r == (width_r - ONE_D));
    line_last_s = (line_r == LINE_LAST);
    out_short_s = (width_r < KERN_D);
    out_last_s  = (out_col_r == (width_r - KERN_D));
  end

  // Configuration and totals captured at frame start
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      width_r       <= ZERO_D;
      start_base_r  <= ZERO_A;
      finish_base_r <= ZERO_A;
      rc_base_r     <= ZERO_A;
      out_base_r    <= ZERO_A;
      rd_total_r    <= ZERO_T;
      wr_total_r    <= ZERO_T;
    end else if (start_flag) begin
      width_r       <= image_width;
      start_base_r  <= start_address_sdram;
      finish_base_r <= finish_address_sdram;
      rc_base_r     <= rowCache_address_sram;
      out_base_r    <= output_address_sram;
      rd_total_r    <= rd_total_s;
      wr_total_r    <= wr_total_s;
    end
  end

  // SDRAM frame read pointer; freezes once the whole frame has been read
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rd_off_r    <= ZERO_A;
      rd_cnt_r    <= ZERO_T;
      read_done_r <= 1'b0;
    end else if (start_flag) begin
      rd_off_r    <= ZERO_A;
      rd_cnt_r    <= ZERO_T;
      read_done_r <= (rd_total_s == ZERO_T);
    end else if (sdram_update && sdram_mode && !read_done_r) begin
      rd_off_r    <= rd_off_r + ONE_A;
      rd_cnt_r    <= rd_cnt_r + ONE_T;
      read_done_r <= ((rd_cnt_r + ONE_T) == rd_total_r);
    end
  end

  // SDRAM result write pointer; freezes once every output pixel is written
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_off_r     <= ZERO_A;
      wr_cnt_r     <= ZERO_T;
      write_done_r <= 1'b0;
    end else if (start_flag) begin
      wr_off_r     <= ZERO_A;
      wr_cnt_r     <= ZERO_T;
      write_done_r <= (wr_total_s == ZERO_T);
    end else if (sdram_update && !sdram_mode && !write_done_r) begin
      wr_off_r     <= wr_off_r + ONE_A;
      wr_cnt_r     <= wr_cnt_r + ONE_T;
      write_done_r <= ((wr_cnt_r + ONE_T) == wr_total_r);
    end
  end

  // Row-cache ring: line_base accumulates width so no multiplier is needed
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      col_r       <= ZERO_D;
      line_r      <= LINE_ZERO;
      line_base_r <= ZERO_A;
      row_wrap_r  <= 1'b0;
    end else if (start_flag) begin
      col_r       <= ZERO_D;
      line_r      <= LINE_ZERO;
      line_base_r <= ZERO_A;
      row_wrap_r  <= 1'b0;
    end else begin
      row_wrap_r <= 1'b0;
      if (sram_update && sram_mode) begin
        if (col_last_s) begin
          col_r      <= ZERO_D;
          row_wrap_r <= 1'b1;
          if (line_last_s) begin
            line_r      <= LINE_ZERO;
            line_base_r <= ZERO_A;
          end else begin
            line_r      <= line_r + LINE_ONE;
            line_base_r <= line_base_r + ADDR_W'(width_r);
          end
        end else begin
          col_r <= col_r + ONE_D;
        end
      end
    end
  end

  // Output line pointer over the kernel-trimmed width
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      out_col_r <= ZERO_D;
    end else if (start_flag) begin
      out_col_r <= ZERO_D;
    end else if (sram_update && !sram_mode) begin
      if (out_short_s || out_last_s) begin
        out_col_r <= ZERO_D;
      end else begin
        out_col_r <= out_col_r + ONE_D;
      end
    end
  end

  // Mode-selected address outputs, combinational so mode switches act at once
  always_comb begin
    if (sram_mode) begin
      sram_address = rc_base_r + line_base_r + ADDR_W'(col_r);
    end else begin
      sram_address = out_base_r + ADDR_W'(out_col_r);
    end
    if (sdram_mode) begin
      sdram_address = start_base_r + rd_off_r;
    end else begin
      sdram_address = finish_base_r + wr_off_r;
    end
  end

  assign row_line   = line_r;
  assign row_wrap   = row_wrap_r;
  assign read_done  = read_done_r;
  assign write_done = write_done_r;

endmodule

// File: tb/tb_address_calc_ring.sv
// Directed testbench for address_calc_ring (ROWS=3, KERNEL=3, 30x4 frame).
module tb_address_calc_ring;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        start_flag;
  logic [12:0] image_width, image_height;
  logic [25:0] start_address_sdram, finish_address_sdram;
  logic [25:0] rowCache_address_sram, output_address_sram;
  logic        sram_mode, sdram_mode, sram_update, sdram_update;
  logic [25:0] sram_address, sdram_address;
  logic [1:0]  row_line;
  logic        row_wrap, read_done, write_done;

  int checks = 0;
  int errors = 0;

  address_calc_ring #(.ADDR_W(26), .DIM_W(13), .ROWS(3), .KERNEL(3)) dut (
    .clk(clk), .n_rst(n_rst), .start_flag(start_flag),
    .image_width(image_width), .image_height(image_height),
    .start_address_sdram(start_address_sdram), .finish_address_sdram(finish_address_sdram),
    .rowCache_address_sram(rowCache_address_sram), .output_address_sram(output_address_sram),
    .sram_mode(sram_mode), .sdram_mode(sdram_mode),
    .sram_update(sram_update), .sdram_update(sdram_update),
    .sram_address(sram_address), .sdram_address(sdram_address),
    .row_line(row_line), .row_wrap(row_wrap),
    .read_done(read_done), .write_done(write_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start_flag = 1'b1;
    tick();
    start_flag = 1'b0;
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    #2;
    checks++; if (sram_address !== 26'd0) begin errors++; $display("FAIL rst_sram got %0d exp 0", sram_address); end
    checks++; if (sdram_address !== 26'd0) begin errors++; $display("FAIL rst_sdram got %0d exp 0", sdram_address); end
    checks++; if ({row_line, row_wrap, read_done, write_done} !== 5'd0) begin errors++; $display("FAIL rst_flags got %b exp 00000", {row_line, row_wrap, read_done, write_done}); end
    tick();
    n_rst = 1'b1;
    tick();
    // width 2 gives an empty output frame, so write_done is set by the start
    image_width = 13'd2;
    do_start();
    sram_mode = 1'b1; sdram_mode = 1'b1; sram_update = 1'b1; sdram_update = 1'b1;
    tick(); tick();
    sram_update = 1'b0; sdram_update = 1'b0;
    checks++; if (sram_address !== 26'd2) begin errors++; $display("FAIL pre_rst_sram got %0d exp 2", sram_address); end
    checks++; if (sdram_address !== 26'd302) begin errors++; $display("FAIL pre_rst_sdram got %0d exp 302", sdram_address); end
    checks++; if ({row_line, row_wrap, write_done} !== 4'b0111) begin errors++; $display("FAIL pre_rst_flags got %b exp 0111", {row_line, row_wrap, write_done}); end
    #3;
    n_rst = 1'b0;
    #1;
    checks++; if (sram_address !== 26'd0) begin errors++; $display("FAIL mid_rst_sram got %0d exp 0", sram_address); end
    checks++; if (sdram_address !== 26'd0) begin errors++; $display("FAIL mid_rst_sdram got %0d exp 0", sdram_address); end
    checks++; if ({row_line, row_wrap, read_done, write_done} !== 5'd0) begin errors++; $display("FAIL mid_rst_flags got %b exp 00000", {row_line, row_wrap, read_done, write_done}); end
    #1;
    n_rst = 1'b1;
    image_width = 13'd30;
    tick();
  endtask

  task automatic test_row_cache();
    do_start();
    sram_mode = 1'b1;
    checks++; if (sram_address !== 26'd0) begin errors++; $display("FAIL rc_start got %0d exp 0", sram_address); end
    sram_update = 1'b1;
    for (int i = 1; i <= 90; i++) begin
      tick();
      checks++; if (sram_address !== 26'(i % 90)) begin errors++; $display("FAIL rc_addr upd %0d got %0d exp %0d", i, sram_address, i % 90); end
      checks++; if (row_line !== 2'((i / 30) % 3)) begin errors++; $display("FAIL rc_line upd %0d got %0d exp %0d", i, row_line, (i / 30) % 3); end
      checks++; if (row_wrap !== ((i % 30) == 0)) begin errors++; $display("FAIL rc_wrap upd %0d got %0b exp %0b", i, row_wrap, (i % 30) == 0); end
    end
    sram_update = 1'b0;
    tick();
    checks++; if (row_wrap !== 1'b0) begin errors++; $display("FAIL rc_wrap_pulse got %0b exp 0", row_wrap); end
    checks++; if (sram_address !== 26'd0) begin errors++; $display("FAIL rc_idle got %0d exp 0", sram_address); end
  endtask

  task automatic test_output_line();
    sram_mode = 1'b1; sram_update = 1'b1;
    repeat (5) tick();
    sram_update = 1'b0;
    checks++; if (sram_address !== 26'd5) begin errors++; $display("FAIL ol_rc_pre got %0d exp 5", sram_address); end
    sram_mode = 1'b0;
    #1;
    checks++; if (sram_address !== 26'd42) begin errors++; $display("FAIL ol_first got %0d exp 42", sram_address); end
    sram_update = 1'b1;
    for (int i = 1; i <= 28; i++) begin
      tick();
      checks++; if (sram_address !== 26'(42 + (i % 28))) begin errors++; $display("FAIL ol_addr upd %0d got %0d exp %0d", i, sram_address, 42 + (i % 28)); end
    end
    sram_update = 1'b0;
    sram_mode = 1'b1;
    #1;
    checks++; if (sram_address !== 26'd5) begin errors++; $display("FAIL ol_rc_hold got %0d exp 5", sram_address); end
    checks++; if (row_line !== 2'd0) begin errors++; $display("FAIL ol_line_hold got %0d exp 0", row_line); end
  endtask

  task automatic test_frame();
    sdram_mode = 1'b1;
    #1;
    checks++; if (sdram_address !== 26'd300) begin errors++; $display("FAIL rd_first got %0d exp 300", sdram_address); end
    sdram_update = 1'b1;
    for (int i = 1; i <= 121; i++) begin
      tick();
      checks++; if (sdram_address !== 26'(300 + ((i > 120) ? 120 : i))) begin errors++; $display("FAIL rd_addr upd %0d got %0d exp %0d", i, sdram_address, 300 + ((i > 120) ? 120 : i)); end
      checks++; if (read_done !== (i >= 120)) begin errors++; $display("FAIL rd_done upd %0d got %0b exp %0b", i, read_done, i >= 120); end
    end
    sdram_update = 1'b0;
    sdram_mode = 1'b0;
    #1;
    checks++; if (sdram_address !== 26'd3000) begin errors++; $display("FAIL wr_first got %0d exp 3000", sdram_address); end
    sdram_update = 1'b1;
    for (int i = 1; i <= 57; i++) begin
      tick();
      checks++; if (sdram_address !== 26'(3000 + ((i > 56) ? 56 : i))) begin errors++; $display("FAIL wr_addr upd %0d got %0d exp %0d", i, sdram_address, 3000 + ((i > 56) ? 56 : i)); end
      checks++; if (write_done !== (i >= 56)) begin errors++; $display("FAIL wr_done upd %0d got %0b exp %0b", i, write_done, i >= 56); end
    end
    sdram_update = 1'b0;
    sdram_mode = 1'b1;
    #1;
    checks++; if (sdram_address !== 26'd420) begin errors++; $display("FAIL rd_hold got %0d exp 420", sdram_address); end
  endtask

  task automatic test_priority();
    do_start();
    checks++; if ({read_done, write_done} !== 2'b00) begin errors++; $display("FAIL pr_done_clr got %b exp 00", {read_done, write_done}); end
    sdram_mode = 1'b1; sdram_update = 1'b1;
    repeat (10) tick();
    checks++; if (sdram_address !== 26'd310) begin errors++; $display("FAIL pr_pre got %0d exp 310", sdram_address); end
    sram_mode = 1'b1; sram_update = 1'b1;
    repeat (4) tick();
    start_flag = 1'b1;
    tick();
    start_flag = 1'b0; sdram_update = 1'b0; sram_update = 1'b0;
    checks++; if (sdram_address !== 26'd300) begin errors++; $display("FAIL pr_sdram got %0d exp 300", sdram_address); end
    checks++; if (read_done !== 1'b0) begin errors++; $display("FAIL pr_rd_done got %0b exp 0", read_done); end
    checks++; if (sram_address !== 26'd0) begin errors++; $display("FAIL pr_sram got %0d exp 0", sram_address); end
    sram_update = 1'b1;
    repeat (3) tick();
    sram_mode = 1'b0;
    tick();
    sram_update = 1'b0;
    checks++; if (sram_address !== 26'd43) begin errors++; $display("FAIL pr_out got %0d exp 43", sram_address); end
    sram_mode = 1'b1;
    #1;
    checks++; if (sram_address !== 26'd3) begin errors++; $display("FAIL pr_rc_hold got %0d exp 3", sram_address); end
  endtask

  task automatic test_degenerate();
    image_width = 13'd2;
    do_start();
    checks++; if (write_done !== 1'b1) begin errors++; $display("FAIL dg_wr_done got %0b exp 1", write_done); end
    checks++; if (read_done !== 1'b0) begin errors++; $display("FAIL dg_rd_done got %0b exp 0", read_done); end
    sdram_mode = 1'b0; sdram_update = 1'b1;
    repeat (5) tick();
    sdram_update = 1'b0;
    checks++; if (sdram_address !== 26'd3000) begin errors++; $display("FAIL dg_wr_addr got %0d exp 3000", sdram_address); end
    sram_mode = 1'b0; sram_update = 1'b1;
    repeat (3) tick();
    sram_update = 1'b0;
    checks++; if (sram_address !== 26'd42) begin errors++; $display("FAIL dg_out_addr got %0d exp 42", sram_address); end
  endtask

  initial begin
    start_flag = 1'b0;
    image_width = 13'd30; image_height = 13'd4;
    start_address_sdram = 26'd300; finish_address_sdram = 26'd3000;
    rowCache_address_sram = 26'd0; output_address_sram = 26'd42;
    sram_mode = 1'b0; sdram_mode = 1'b0; sram_update = 1'b0; sdram_update = 1'b0;
    test_reset();
    test_row_cache();
    test_output_line();
    test_frame();
    test_priority();
    test_degenerate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
